// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// alu_cmd_sequencer: assembles A/B/OP command bytes from the UART, drives the ALU,
// hands the result to the transmitter, with inter-byte timeout and a one-deep pending-byte buffer.
module alu_cmd_sequencer #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_TIMER = 16,
  parameter int TIMEOUT  = 1600
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_dato_A,
  output logic [NB_DATA-1:0] o_dato_B,
  output logic [NB_OP-1:0]   o_OP,
  output logic [NB_DATA-1:0] o_interface_data,
  output logic               o_interface_done,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [NB_TIMER-1:0] timer;
  logic                pend_valid;
  logic [NB_DATA-1:0]  pend_data;

  logic load_a, a_from_pend, load_b, load_op, load_res, clr_timer;
  logic pend_store, pend_clr, timeout_nxt, overrun_nxt;
  logic timer_hit, timer_run;

  // Upper rx bits are not part of the opcode.
  logic unused_rx_bits;
  assign unused_rx_bits = ^i_rx_data[NB_DATA-1:NB_OP];

  assign timer_run = (state == WAIT_B || state == WAIT_OP) && i_tick;
  assign timer_hit = timer_run && (timer == NB_TIMER'(TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    load_a      = 1'b0;
    a_from_pend = 1'b0;
    load_b      = 1'b0;
    load_op     = 1'b0;
    load_res    = 1'b0;
    clr_timer   = 1'b0;
    pend_store  = 1'b0;
    pend_clr    = 1'b0;
    timeout_nxt = 1'b0;
    overrun_nxt = 1'b0;
    case (state)
      IDLE: if (i_rx_done) begin
        load_a    = 1'b1;
        clr_timer = 1'b1;
        state_nxt = WAIT_B;
      end
      WAIT_B: if (i_rx_done) begin
        load_b    = 1'b1;
        clr_timer = 1'b1;
        state_nxt = WAIT_OP;
      end else if (timer_hit) begin
        timeout_nxt = 1'b1;
        state_nxt   = IDLE;
      end
      WAIT_OP: if (i_rx_done) begin
        load_op   = 1'b1;
        state_nxt = EXEC;
      end else if (timer_hit) begin
        timeout_nxt = 1'b1;
        state_nxt   = IDLE;
      end
      EXEC, SEND: begin
        load_res  = (state == EXEC);
        state_nxt = (state == EXEC) ? SEND : WAIT_TX;
        if (i_rx_done) begin
          pend_store  = !pend_valid;
          overrun_nxt = pend_valid;
        end
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          // A buffered byte is older than one arriving now, so it wins the A slot.
          if (pend_valid) begin
            load_a      = 1'b1;
            a_from_pend = 1'b1;
            pend_clr    = 1'b1;
            clr_timer   = 1'b1;
            overrun_nxt = i_rx_done;
            state_nxt   = WAIT_B;
          end else if (i_rx_done) begin
            load_a    = 1'b1;
            clr_timer = 1'b1;
            state_nxt = WAIT_B;
          end else begin
            state_nxt = IDLE;
          end
        end else if (i_rx_done) begin
          pend_store  = !pend_valid;
          overrun_nxt = pend_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state            <= IDLE;
      o_dato_A         <= '0;
      o_dato_B         <= '0;
      o_OP             <= '0;
      o_interface_data <= '0;
      o_timeout        <= 1'b0;
      o_overrun        <= 1'b0;
      timer            <= '0;
      pend_valid       <= 1'b0;
      pend_data        <= '0;
    end else begin
      state     <= state_nxt;
      o_timeout <= timeout_nxt;
      o_overrun <= overrun_nxt;
      if (load_a)   o_dato_A         <= a_from_pend ? pend_data : i_rx_data;
      if (load_b)   o_dato_B         <= i_rx_data;
      if (load_op)  o_OP             <= i_rx_data[NB_OP-1:0];
      if (load_res) o_interface_data <= i_alu_result;
      if (clr_timer)
        timer <= '0;
      else if (timer_run && timer != '1)
        timer <= timer + NB_TIMER'(1);
      if (pend_clr) begin
        pend_valid <= 1'b0;
      end else if (pend_store) begin
        pend_valid <= 1'b1;
        pend_data  <= i_rx_data;
      end
    end
  end

  assign o_interface_done = (state == SEND);
  assign o_busy           = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// tb_alu_cmd_sequencer: directed and randomized checks of the command sequencer
// against a transaction-level model of commands, pending bytes and overruns.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, rx_done, tx_done;
  logic [7:0] rx_data, alu_res;
  logic [7:0] dato_a, dato_b, if_data;
  logic [5:0] op_out;
  logic       if_done, busy, timeout, overrun;

  int n_checks = 0, n_pass = 0;
  int done_cnt = 0, ovr_cnt = 0, tmo_cnt = 0;
  bit fast_tick = 1'b0;
  int tick_div = 0;
  logic [7:0] last_res;
  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .i_tick           (tick),
    .i_rx_data        (rx_data),
    .i_rx_done        (rx_done),
    .i_alu_result     (alu_res),
    .i_tx_done        (tx_done),
    .o_dato_A         (dato_a),
    .o_dato_B         (dato_b),
    .o_OP             (op_out),
    .o_interface_data (if_data),
    .o_interface_done (if_done),
    .o_busy           (busy),
    .o_timeout        (timeout),
    .o_overrun        (overrun)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [7:0] r;
    case (op)
      6'h20:   r = a + b;
      6'h22:   r = a - b;
      6'h24:   r = a & b;
      6'h25:   r = a | b;
      6'h26:   r = a ^ b;
      6'h27:   r = ~(a | b);
      6'h02:   r = a >> b;
      6'h03:   r = $signed(a) >>> b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Behavioural ALU sitting on the DUT operand outputs.
  always_comb alu_res = alu_ref(dato_a, dato_b, op_out);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    if (fast_tick) tick = 1'b1;
    else begin
      tick_div++;
      tick = (tick_div % 16 == 0);
    end
    @(posedge clk);
    #1;
    if (if_done) done_cnt++;
    if (overrun) ovr_cnt++;
    if (timeout) tmo_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic tx_finish();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {dato_a, dato_b, op_out, if_data, if_done, busy, timeout, overrun}, 64'h0);
  endtask

  // Sends a command (A optionally already loaded) and leaves the DUT in WAIT_TX.
  task automatic run_cmd(input bit send_a, input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    logic [7:0] exp;
    int d0;
    exp = alu_ref(a, b, opb[5:0]);
    if (send_a) begin
      send_byte(a);
      idle($urandom_range(0, 3));
    end
    send_byte(b);
    idle($urandom_range(0, 3));
    d0 = done_cnt;
    send_byte(opb);
    check_val("opnd_a", dato_a, a);
    check_val("opnd_b", dato_b, b);
    check_val("opcode", op_out, opb[5:0]);
    check_val("no_done_n1", if_done, 0);
    step();
    check_val("done_n2", if_done, 1);
    check_val("result", if_data, exp);
    step();
    check_val("done_width", if_done, 0);
    check_val("done_count", done_cnt - d0, 1);
    check_val("busy_wait_tx", busy, 1);
    last_res = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] a_next, a, b, opb, x;
    bit have_a;
    int exp_ovr, d0, k;

    rst_n = 1'b0; tick = 1'b0; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
    #1;
    check_all_zero("reset_async");
    idle(3);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    idle(2);

    // Basic ADD
    run_cmd(1'b1, 8'h05, 8'h03, 8'h20);
    check_val("add_05_03", if_data, 8'h08);
    idle(3);
    tx_finish();
    check_val("busy_after_tx", busy, 0);

    // Inter-byte timeout on the 1600th tick
    send_byte(8'h11);
    fast_tick = 1'b1;
    idle(1599);
    check_val("no_timeout_1599", {busy, 8'(tmo_cnt)}, {1'b1, 8'd0});
    step();
    check_val("timeout_pulse", {timeout, busy}, {1'b1, 1'b0});
    step();
    check_val("timeout_width", {timeout, 8'(tmo_cnt)}, {1'b0, 8'd1});
    check_val("a_kept", dato_a, 8'h11);
    fast_tick = 1'b0;
    run_cmd(1'b1, 8'h0F, 8'h01, 8'h22);
    check_val("sub_0f_01", if_data, 8'h0E);
    idle(2);
    // Pending byte becomes next A
    send_byte(8'h07);
    idle(2);
    check_val("pend_busy", busy, 1);
    tx_finish();
    check_val("pend_a", {busy, dato_a}, {1'b1, 8'h07});
    run_cmd(1'b0, 8'h07, 8'h02, 8'h20);
    check_val("add_07_02", if_data, 8'h09);
    // Second byte during WAIT_TX overruns
    exp_ovr = ovr_cnt;
    send_byte(8'h07);
    send_byte(8'h09);
    check_val("overrun_pulse", overrun, 1);
    step();
    check_val("overrun_count", ovr_cnt - exp_ovr, 1);
    tx_finish();
    check_val("ovr_next_a", dato_a, 8'h07);
    run_cmd(1'b0, 8'h07, 8'h04, 8'h26);
    // rx_done coincident with tx_done, buffer empty
    exp_ovr = ovr_cnt;
    rx_data = 8'h44; rx_done = 1'b1; tx_done = 1'b1;
    step();
    rx_done = 1'b0; tx_done = 1'b0;
    check_val("coinc_a", {busy, dato_a}, {1'b1, 8'h44});
    check_val("coinc_no_ovr", ovr_cnt - exp_ovr, 0);
    run_cmd(1'b0, 8'h44, 8'h11, 8'h25);
    tx_finish();
    check_val("coinc_idle", busy, 0);

    // Randomized command stream against the transaction model
    have_a = 1'b0;
    a_next = 8'h00;
    for (int it = 0; it < 40; it++) begin
      a   = have_a ? a_next : 8'($urandom);
      b   = 8'($urandom);
      opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
      run_cmd(!have_a, a, b, opb);
      exp_ovr = ovr_cnt;
      d0 = done_cnt;
      have_a = 1'b0;
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        idle($urandom_range(0, 3));
        x = 8'($urandom);
        send_byte(x);
        if (!have_a) begin have_a = 1'b1; a_next = x; end
        else exp_ovr++;
      end
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        x = 8'($urandom);
        rx_data = x; rx_done = 1'b1; tx_done = 1'b1;
        step();
        rx_done = 1'b0; tx_done = 1'b0;
        if (!have_a) begin have_a = 1'b1; a_next = x; end
        else exp_ovr++;
      end else begin
        tx_finish();
      end
      step();
      check_val("rnd_ovr_count", ovr_cnt, exp_ovr);
      check_val("rnd_busy", busy, have_a);
      check_val("rnd_data_hold", if_data, last_res);
      check_val("rnd_no_extra_done", done_cnt - d0, 0);
      if (have_a) check_val("rnd_next_a", dato_a, a_next);
    end
    if (have_a) begin
      run_cmd(1'b0, a_next, 8'h01, 8'h20);
      tx_finish();
    end
    idle(2);

    // Asynchronous reset in WAIT_OP
    send_byte(8'h21);
    send_byte(8'h22);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_wait_op");
    idle(2);
    rst_n = 1'b1;
    d0 = done_cnt;
    idle(5);
    check_val("rst_no_done", done_cnt - d0, 0);
    run_cmd(1'b1, 8'h30, 8'h0C, 8'h24);
    // Asynchronous reset in WAIT_TX with a byte pending
    send_byte(8'h33);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_wait_tx");
    idle(2);
    rst_n = 1'b1;
    d0 = done_cnt;
    idle(5);
    check_val("rst2_no_done", done_cnt - d0, 0);
    run_cmd(1'b1, 8'h50, 8'h05, 8'h22);
    tx_finish();
    check_val("rst_pend_cleared", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
